// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, discards responses made stale by redirect/trap.
// Instruction is registered to decode one cycle after rvalid and held stable until instr_ready or a redirect event.
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0010)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_offset,
  input  logic            trap,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_ipc;

  logic            w_event;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_inc;
  logic            w_load;

  assign w_event  = trap | redirect_valid;
  assign w_sum    = redirect_base + redirect_offset;
  assign w_target = trap ? TRAP_VEC : {w_sum[XLEN-1:2], 2'b00};
  assign w_pc_inc = r_pc + XLEN'(4);
  // A response is only kept when no event arrives with it in WAIT; in DROP it is always stale.
  assign w_load   = (r_state == WAIT) && imem_rvalid && !w_event;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = FETCH;
      FETCH:   if (!w_event && imem_gnt) w_state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)  w_state_nxt = w_event ? FETCH : HOLD;
        else if (w_event) w_state_nxt = DROP;
      end
      DROP:    if (imem_rvalid) w_state_nxt = FETCH;
      HOLD:    if (w_event || instr_ready) w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == FETCH) && !w_event;
    imem_addr = r_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
    end else begin
      if ((r_state != IDLE) && w_event) r_pc <= w_target;
      else if (w_load)                  r_pc <= w_pc_inc;

      if (w_load) begin
        r_instr <= imem_rdata;
        r_ipc   <= r_pc;
        r_valid <= 1'b1;
      end else if ((r_state == HOLD) && (w_event || instr_ready)) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign instr_valid = r_valid;
  assign instr_out   = r_instr;
  assign instr_pc    = r_ipc;
  assign pc_q        = r_pc;

endmodule
